// File: rtl/mbus_defs.sv
// Shared definitions for the Modbus frame datapath: transmitter FSM state
// encodings, CRC16/MODBUS constants and default frame limits.
package mbus_defs;

  // Transmitter FSM states
  localparam logic [2:0] TFS_IDLE = 3'd0;
  localparam logic [2:0] TFS_RD   = 3'd1;
  localparam logic [2:0] TFS_WT   = 3'd2;
  localparam logic [2:0] TFS_SEND = 3'd3;
  localparam logic [2:0] TFS_CRCL = 3'd4;
  localparam logic [2:0] TFS_CRCH = 3'd5;
  localparam logic [2:0] TFS_GAP  = 3'd6;

  // CRC16/MODBUS: reflected polynomial, all-ones seed, no final xor
  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Default frame limits
  localparam logic [10:0] TFS_MAX_LEN = 11'd1024;
  localparam logic [15:0] TFS_IFG_CYC = 16'd64;

endpackage

// File: rtl/crc16_byte.sv
// Combinational one-byte CRC16/MODBUS update (LSB-first, reflected form).
module crc16_byte
  import mbus_defs::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] w_acc;

  // Fold the byte into the low half, then eight shift/conditional-xor steps
  always_comb begin
    w_acc = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      if (w_acc[0]) begin
        w_acc = (w_acc >> 1) ^ CRC_POLY;
      end else begin
        w_acc = w_acc >> 1;
      end
    end
    crc_out = w_acc;
  end

endmodule

// File: rtl/tx_frame_send.sv
// Frame transmitter: reads a payload from the TX frame buffer, streams it to
// the line driver over valid/ready, appends CRC16/MODBUS (low byte first),
// then holds off new starts for an inter-frame gap.
module tx_frame_send
  import mbus_defs::*;
#(
  parameter logic [10:0] MAX_LEN = TFS_MAX_LEN,
  parameter logic [15:0] IFG_CYC = TFS_IFG_CYC
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [10:0] tx_data_len,
  input  logic [7:0]  tx_buf_rdata,
  output logic        tx_buf_rden,
  output logic [10:0] tx_buf_raddr,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_vld,
  input  logic        tx_byte_rdy,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_err
);

  // FSM and registered outputs
  logic [2:0]  r_state;
  logic        r_rden;
  logic [10:0] r_raddr;
  logic [7:0]  r_byte;
  logic        r_vld;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  // Frame bookkeeping
  logic [10:0] r_len;
  logic [10:0] r_idx;
  logic [15:0] r_crc;
  logic [15:0] r_gap_cnt;

  // Combinational helpers
  logic        w_xfer;
  logic        w_len_ok;
  logic        w_accept;
  logic [11:0] w_idx_inc;
  logic        w_more;
  logic [16:0] w_gap_inc;
  logic        w_gap_last;
  logic [15:0] w_crc_next;

  assign w_xfer     = r_vld & tx_byte_rdy;
  assign w_len_ok   = (tx_data_len != 11'd0) && (tx_data_len <= MAX_LEN);
  assign w_accept   = (r_state == TFS_IDLE) && tx_start && w_len_ok;
  // 12-bit compare so that a full MAX_LEN frame cannot wrap the index test
  assign w_idx_inc  = {1'b0, r_idx} + 12'd1;
  assign w_more     = w_idx_inc < {1'b0, r_len};
  assign w_gap_inc  = {1'b0, r_gap_cnt} + 17'd1;
  assign w_gap_last = w_gap_inc >= {1'b0, IFG_CYC};

  crc16_byte u_crc (
    .crc_in  (r_crc),
    .data    (r_byte),
    .crc_out (w_crc_next)
  );

  assign tx_buf_rden  = r_rden;
  assign tx_buf_raddr = r_raddr;
  assign tx_byte      = r_byte;
  assign tx_byte_vld  = r_vld;
  assign tx_busy      = r_busy;
  assign tx_done      = r_done;
  assign tx_err       = r_err;

  // Frame sequencer; every output is registered and set on entry to its state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= TFS_IDLE;
      r_rden  <= 1'b0;
      r_raddr <= 11'd0;
      r_byte  <= 8'h00;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_rden <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        TFS_IDLE: begin
          if (tx_start) begin
            if (w_len_ok) begin
              r_state <= TFS_RD;
              r_rden  <= 1'b1;
              r_raddr <= 11'd0;
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        TFS_RD: begin
          // rden was raised on entry; the buffer answers during WT
          r_state <= TFS_WT;
        end
        TFS_WT: begin
          r_byte  <= tx_buf_rdata;
          r_vld   <= 1'b1;
          r_state <= TFS_SEND;
        end
        TFS_SEND: begin
          if (w_xfer) begin
            if (w_more) begin
              r_vld   <= 1'b0;
              r_state <= TFS_RD;
              r_rden  <= 1'b1;
              r_raddr <= w_idx_inc[10:0];
            end else begin
              // Last payload byte accepted: present the finished CRC low
              // byte straight away so vld stays high across the boundary
              r_byte  <= w_crc_next[7:0];
              r_state <= TFS_CRCL;
            end
          end
        end
        TFS_CRCL: begin
          if (w_xfer) begin
            r_byte  <= r_crc[15:8];
            r_state <= TFS_CRCH;
          end
        end
        TFS_CRCH: begin
          if (w_xfer) begin
            r_vld   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= TFS_GAP;
          end
        end
        TFS_GAP: begin
          if (w_gap_last) begin
            r_state <= TFS_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= TFS_IDLE;
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Latched length, byte index and running CRC over the accepted payload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len <= 11'd0;
      r_idx <= 11'd0;
      r_crc <= CRC_INIT;
    end else if (w_accept) begin
      r_len <= tx_data_len;
      r_idx <= 11'd0;
      r_crc <= CRC_INIT;
    end else if ((r_state == TFS_SEND) && w_xfer) begin
      r_crc <= w_crc_next;
      r_idx <= w_idx_inc[10:0];
    end
  end

  // Inter-frame gap counter, cleared as the CRC high byte leaves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gap_cnt <= 16'd0;
    end else if ((r_state == TFS_CRCH) && w_xfer) begin
      r_gap_cnt <= 16'd0;
    end else if (r_state == TFS_GAP) begin
      r_gap_cnt <= w_gap_inc[15:0];
    end
  end

endmodule

// File: tb/tb_tx_frame_send.sv
// Scoreboard bench for tx_frame_send: expected line bytes are queued when a
// frame is started and compared as each vld&rdy transfer is observed.
`timescale 1ns/1ps
module tb_tx_frame_send;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_start = 1'b0;
  logic [10:0] tx_data_len = 11'd0;
  logic [7:0]  tx_buf_rdata = 8'h00;
  logic        tx_buf_rden;
  logic [10:0] tx_buf_raddr;
  logic [7:0]  tx_byte;
  logic        tx_byte_vld;
  logic        tx_byte_rdy = 1'b0;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_err;

  always #5 clk = ~clk;

  tx_frame_send dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .tx_data_len  (tx_data_len),
    .tx_buf_rdata (tx_buf_rdata),
    .tx_buf_rden  (tx_buf_rden),
    .tx_buf_raddr (tx_buf_raddr),
    .tx_byte      (tx_byte),
    .tx_byte_vld  (tx_byte_vld),
    .tx_byte_rdy  (tx_byte_rdy),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_err       (tx_err)
  );

  // Frame buffer model: one-clock read latency
  logic [7:0] mem [0:2047];
  always @(posedge clk) if (tx_buf_rden) tx_buf_rdata <= mem[tx_buf_raddr];

  int n_chk = 0;
  int n_err = 0;
  int n_xfer = 0;
  int n_done = 0;
  int n_errp = 0;
  int n_rden = 0;
  int exp_addr = 0;
  int rdy_mode = 0;
  logic [7:0] q [$];
  logic hold_prev = 1'b0;
  logic [7:0] hold_byte = 8'h00;
  logic s_busy = 1'b0;
  logic s_vld = 1'b0;

  localparam logic [7:0] T1_FRAME [8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference CRC, bit-serial form
  function automatic logic [15:0] model_crc(input int len);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      b = mem[i];
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic push_model(input int len);
    logic [15:0] c;
    for (int i = 0; i < len; i++) q.push_back(mem[i]);
    c = model_crc(len);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
  endtask

  task automatic load_t1();
    for (int i = 0; i < 6; i++) mem[i] = T1_FRAME[i];
  endtask

  task automatic push_t1();
    for (int i = 0; i < 8; i++) q.push_back(T1_FRAME[i]);
  endtask

  // Observe the DUT between edges
  task automatic monitor();
    s_busy = tx_busy;
    s_vld  = tx_byte_vld;
    if (!reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk_eq("hold_vld", tx_byte_vld, 1);
        chk_eq("hold_byte", tx_byte, hold_byte);
      end
      if (tx_buf_rden) begin
        chk_eq("raddr", tx_buf_raddr, exp_addr);
        exp_addr++;
        n_rden++;
      end
      if (tx_err) n_errp++;
      if (tx_done) begin
        n_done++;
        chk_eq("done_after_crch", q.size(), 0);
      end
      if (tx_byte_vld && tx_byte_rdy) begin
        n_xfer++;
        if (q.size() == 0) chk_eq("spurious_byte", q.size(), 1);
        else chk_eq("line_byte", tx_byte, q.pop_front());
      end
      hold_prev = tx_byte_vld && !tx_byte_rdy;
      hold_byte = tx_byte;
    end
  endtask

  // One clock: drive rdy just after the rising edge, observe at the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       tx_byte_rdy = 1'b1;
      1:       tx_byte_rdy = ($urandom_range(0, 99) < 30);
      default: tx_byte_rdy = 1'b0;
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic pulse_start(input logic [10:0] len);
    tx_start = 1'b1;
    tx_data_len = len;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc, input int limit);
    cyc = s_busy ? 1 : 0;
    while (1) begin
      tick();
      if (!s_busy) break;
      cyc++;
      if (cyc > limit) begin
        chk_eq("idle_timeout", s_busy, 0);
        break;
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_eq({tag, "_busy"}, tx_busy, 0);
    chk_eq({tag, "_vld"}, tx_byte_vld, 0);
    chk_eq({tag, "_done"}, tx_done, 0);
    chk_eq({tag, "_err"}, tx_err, 0);
    chk_eq({tag, "_rden"}, tx_buf_rden, 0);
    chk_eq({tag, "_byte"}, tx_byte, 0);
    chk_eq({tag, "_raddr"}, tx_buf_raddr, 0);
  endtask

  initial begin
    int bc, b_done, b_xfer, b_rden, b_errp, guard;

    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) tick();
    chk_outputs_zero("rst");
    reset = 1'b1;
    tick();

    // T1: reference frame, rdy always high
    load_t1();
    b_done = n_done; b_xfer = n_xfer; b_rden = n_rden;
    exp_addr = 0;
    push_t1();
    pulse_start(11'd6);
    chk_eq("t1_busy_rise", s_busy, 1);
    wait_idle(bc, 6000);
    chk_eq("t1_busy_cycles", bc, 3 * 6 + 2 + 64);
    chk_eq("t1_done", n_done - b_done, 1);
    chk_eq("t1_xfers", n_xfer - b_xfer, 8);
    chk_eq("t1_rden", n_rden - b_rden, 6);
    chk_eq("t1_queue", q.size(), 0);

    // T2: same frame with sparse rdy
    rdy_mode = 1;
    b_done = n_done; b_xfer = n_xfer;
    exp_addr = 0;
    push_t1();
    pulse_start(11'd6);
    wait_idle(bc, 6000);
    chk_eq("t2_done", n_done - b_done, 1);
    chk_eq("t2_xfers", n_xfer - b_xfer, 8);
    chk_eq("t2_queue", q.size(), 0);
    rdy_mode = 0;
    tick();

    // T3: rejected lengths
    b_errp = n_errp; b_rden = n_rden;
    pulse_start(11'd0);
    tick();
    chk_eq("t3_err_len0", n_errp - b_errp, 1);
    chk_eq("t3_busy_len0", s_busy, 0);
    pulse_start(11'd1025);
    tick();
    chk_eq("t3_err_len1025", n_errp - b_errp, 2);
    chk_eq("t3_busy_len1025", s_busy, 0);
    chk_eq("t3_rden", n_rden - b_rden, 0);

    // T4: starts while busy are ignored; restart right after busy falls
    b_done = n_done; b_xfer = n_xfer; b_rden = n_rden; b_errp = n_errp;
    exp_addr = 0;
    push_t1();
    pulse_start(11'd6);
    repeat (4) tick();
    pulse_start(11'd3);
    guard = 0;
    while (n_done == b_done && guard < 500) begin tick(); guard++; end
    chk_eq("t4_done_seen", n_done - b_done, 1);
    repeat (10) tick();
    pulse_start(11'd6);
    wait_idle(bc, 6000);
    chk_eq("t4_done", n_done - b_done, 1);
    chk_eq("t4_xfers", n_xfer - b_xfer, 8);
    chk_eq("t4_rden", n_rden - b_rden, 6);
    chk_eq("t4_no_err", n_errp - b_errp, 0);
    chk_eq("t4_queue", q.size(), 0);
    b_done = n_done;
    exp_addr = 0;
    push_t1();
    pulse_start(11'd6);
    chk_eq("t4_restart_busy", s_busy, 1);
    wait_idle(bc, 6000);
    chk_eq("t4_restart_cycles", bc, 3 * 6 + 2 + 64);
    chk_eq("t4_restart_done", n_done - b_done, 1);

    // T5: reset while the third payload byte is pending
    b_done = n_done; b_xfer = n_xfer; b_errp = n_errp;
    exp_addr = 0;
    push_t1();
    pulse_start(11'd6);
    guard = 0;
    while (n_xfer - b_xfer < 2 && guard < 100) begin tick(); guard++; end
    rdy_mode = 2;
    tick();
    guard = 0;
    while (!s_vld && guard < 20) begin tick(); guard++; end
    chk_eq("t5_pending_vld", s_vld, 1);
    chk_eq("t5_xfers_before", n_xfer - b_xfer, 2);
    reset = 1'b0;
    #1;
    chk_outputs_zero("t5_rst");
    q.delete();
    rdy_mode = 0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk_eq("t5_no_done", n_done - b_done, 0);
    chk_eq("t5_no_err", n_errp - b_errp, 0);
    b_done = n_done; b_xfer = n_xfer;
    exp_addr = 0;
    push_t1();
    pulse_start(11'd6);
    wait_idle(bc, 6000);
    chk_eq("t5_busy_cycles", bc, 3 * 6 + 2 + 64);
    chk_eq("t5_done", n_done - b_done, 1);
    chk_eq("t5_xfers", n_xfer - b_xfer, 8);
    chk_eq("t5_queue", q.size(), 0);

    // T6: maximum length ramp
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
    b_done = n_done; b_xfer = n_xfer; b_rden = n_rden;
    exp_addr = 0;
    push_model(1024);
    pulse_start(11'd1024);
    wait_idle(bc, 6000);
    chk_eq("t6_busy_cycles", bc, 3 * 1024 + 2 + 64);
    chk_eq("t6_rden", n_rden - b_rden, 1024);
    chk_eq("t6_last_addr", exp_addr, 1024);
    chk_eq("t6_xfers", n_xfer - b_xfer, 1026);
    chk_eq("t6_done", n_done - b_done, 1);
    chk_eq("t6_queue", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
